// File: rtl/rs_cmd_gen.sv
// Debounced pushbutton front end that issues clean, mutually exclusive S/R pulses to a gated RS flip-flop.
// Optional build macro INIT_PULSE_EN: issue an automatic R pulse right after reset deasserts.
module rs_cmd_gen #(
  parameter int DB_CYCLES = 4,
  parameter int PULSE_W   = 2
) (
  input  logic CP,
  input  logic RST,
  input  logic BTN_S,
  input  logic BTN_R,
  input  logic Q_FB,
  input  logic QC_FB,
  output logic S,
  output logic R,
  output logic BUSY,
  output logic STATE_EXP,
  output logic ERR
);

  localparam int CW  = $clog2(DB_CYCLES + 1);
  localparam int PWW = (PULSE_W > 1) ? $clog2(PULSE_W) : 1;

  typedef enum logic [1:0] {IDLE, PULSE_S, PULSE_R, SETTLE} state_t;

  logic [1:0] w_btn;
  logic [1:0] w_press;
  logic       w_start_r;

  assign w_btn = {BTN_R, BTN_S};

  // Index 0 is the set button, index 1 the reset button.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_btn
      logic [1:0]    r_sync;
      logic [CW-1:0] r_cnt;
      logic          r_deb;
      logic          r_deb_d;
      logic          r_press;

      always_ff @(posedge CP) begin
        if (RST) begin
          r_sync  <= '0;
          r_cnt   <= '0;
          r_deb   <= 1'b0;
          r_deb_d <= 1'b0;
          r_press <= 1'b0;
        end else begin
          r_sync  <= {r_sync[0], w_btn[gi]};
          r_deb_d <= r_deb;
          r_press <= r_deb & ~r_deb_d;
          if (r_sync[1] == r_deb) begin
            r_cnt <= '0;
          end else if (r_cnt == CW'(DB_CYCLES - 1)) begin
            r_deb <= ~r_deb;
            r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
      end

      assign w_press[gi] = r_press;
    end
  endgenerate

`ifdef INIT_PULSE_EN
  logic r_init;

  // Armed by reset, consumed on the first post-reset edge (FSM is IDLE then).
  always_ff @(posedge CP) begin
    if (RST) begin
      r_init <= 1'b1;
    end else begin
      r_init <= 1'b0;
    end
  end

  assign w_start_r = w_press[1] | r_init;
`else
  assign w_start_r = w_press[1];
`endif

  state_t         r_state;
  logic [PWW-1:0] r_wcnt;
  logic           r_s;
  logic           r_r;
  logic           r_busy;
  logic           r_exp;
  logic           r_err;

  always_ff @(posedge CP) begin
    if (RST) begin
      r_state <= IDLE;
      r_wcnt  <= '0;
      r_s     <= 1'b0;
      r_r     <= 1'b0;
      r_busy  <= 1'b0;
      r_exp   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_wcnt <= '0;
          // Reset has priority when both presses land on the same cycle.
          if (w_start_r) begin
            r_state <= PULSE_R;
            r_r     <= 1'b1;
            r_busy  <= 1'b1;
            r_exp   <= 1'b0;
          end else if (w_press[0]) begin
            r_state <= PULSE_S;
            r_s     <= 1'b1;
            r_busy  <= 1'b1;
            r_exp   <= 1'b1;
          end
        end
        PULSE_S, PULSE_R: begin
          if (r_wcnt == PWW'(PULSE_W - 1)) begin
            r_state <= SETTLE;
            r_s     <= 1'b0;
            r_r     <= 1'b0;
          end else begin
            r_wcnt <= r_wcnt + PWW'(1);
          end
        end
        SETTLE: begin
          if ((Q_FB != r_exp) || (QC_FB != ~r_exp)) begin
            r_err <= 1'b1;
          end
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_s     <= 1'b0;
          r_r     <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign S         = r_s;
  assign R         = r_r;
  assign BUSY      = r_busy;
  assign STATE_EXP = r_exp;
  assign ERR       = r_err;

endmodule
